highscore_table_ctrl: RTL
=========================

# highscore_table_ctrl

Sequential controller that owns the top-3 high-score table shown on the end screen. On a game-over event it ranks the final score against the stored entries. For a qualifying score it runs 3-letter initials entry from debounced buttons, then inserts the new entry and shifts lower entries down. It drives the name1..3 / score1..3 words consumed by the end-screen VGA address processor, plus a live preview of the name being edited.

## Interface
- No parameters.
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high; clears state and table.
- game_over  in  1  one-cycle pulse; sampled only in IDLE.
- final_score  in  16  4-digit BCD score, valid with game_over.
- table_clear  in  1  one-cycle pulse; honoured only in IDLE.
- btn_up, btn_down, btn_confirm  in  1 each  debounced one-cycle pulses.
- name1, name2, name3  out  32  bits [17:12]/[11:6]/[5:0] = char2/char1/char0; [31:18] = 0.
- score1, score2, score3  out  32  bits [15:0] = BCD digits 3..0; [31:16] = 0.
- edit_name  out  18  live initials buffer, same packing as name[17:0].
- cursor  out  2  char under edit: 2, 1 or 0.
- entering  out  1  high in ENTRY.
- rank  out  2  0 = no qualify, 1..3 = slot being filled.
- done  out  1  one-cycle pulse when a game-over sequence completes.

## Operation
- Char codes: 0–9 are digits; A = 10 … Z = 35.
- All outputs are registered. Reset values:
  - names = {10,10,10} ("AAA"), scores = 0.
  - edit_name = {10,10,10}, cursor = 2.
  - entering = 0, rank = 0, done = 0, state = IDLE.
- States:
  - IDLE: on game_over, latch final_score and go to CHECK. On table_clear, reload the reset table values. If both arrive in the same cycle, game_over wins and table_clear is dropped.
  - CHECK (1 cycle): rank = 1 if score > score1, else 2 if > score2, else 3 if > score3, else 0. Comparison is unsigned 16-bit, which is valid for BCD. Ties do not displace (strictly greater). If rank = 0 go to DONE; otherwise set edit_name = AAA and cursor = 2, then go to ENTRY.
  - ENTRY: entering = 1.
    - btn_confirm has priority over up/down.
    - btn_up increments the char at cursor, 35 → 10 wraps.
    - btn_down decrements it, 10 → 35 wraps.
    - up and down together: no change.
    - confirm with cursor 2 → cursor 1; cursor 1 → cursor 0; cursor 0 → INSERT.
  - INSERT (1 cycle): write the slot given by rank.
    - rank 1: entry3 ← entry2, entry2 ← entry1, entry1 ← new.
    - rank 2: entry3 ← entry2, entry2 ← new.
    - rank 3: entry3 ← new.
  - DONE (1 cycle): done = 1, rank held. Then go to IDLE and clear rank.
- game_over and buttons outside their accepting states are ignored, not queued.
- Reset asserted mid-entry aborts immediately; the table returns to reset values.

## Timing
- game_over at edge n → CHECK in cycle n+1 → ENTRY (entering = 1) from cycle n+2.
- Non-qualifying score: done pulses in cycle n+2; no table change.
- Button pulse at edge m → updated edit_name/cursor visible from cycle m+1.
- Final confirm at edge m → INSERT in cycle m+1.
  - New table is visible in cycle m+2, coincident with done = 1.
  - IDLE resumes in cycle m+3.
- Table outputs are stable at all times except the single INSERT edge, so the display never sees a partial shift.

## Structure
- Shared include/package hs_defs:
  - CHAR_A = 10, CHAR_Z = 35.
  - NAME_W = 18, SCORE_W = 16.
  - State encodings IDLE/CHECK/ENTRY/INSERT/DONE.
- One combinational sub-module, hs_rank_compare: inputs are a 16-bit candidate and three 16-bit scores; output is the 2-bit rank. The verification bench reuses it as the reference model.
- FSM, edit buffer and table registers live in highscore_table_ctrl.

## Test plan
- Reset, then game_over with 0x0000 → rank 0, done at n+2, table stays AAA/0000 ×3.
- Empty table, game_over 0x0150; confirm ×3 with no edits → entry1 = AAA/0150, entries 2–3 unchanged, done coincident with the update.
- Table 0900/0500/0100, score 0500:
  - Action: up on char2 to B (11), down on char1 from A to Z (35), confirm ×3.
  - Required response: rank 3, entry3 = {11,35,10}/0500, entries 1–2 unchanged.
- Table 0900/0500/0100, score 0950 → rank 1; table becomes new/0900/0500, and 0100 is dropped.
- In ENTRY:
  - up + down together → char unchanged.
  - up + confirm together → cursor advances, char unchanged.
  - game_over pulse → ignored.
- Reset asserted mid-ENTRY → all outputs return to reset values next cycle. table_clear in IDLE restores AAA/0000 ×3.

Source files
------------

// File: rtl/highscore_table_ctrl_pkg.sv
// Shared definitions for the high-score table controller: char codes, widths, FSM states, table entry.
// Pure declarations; no timing or flow control of its own.
package hs_defs;
    localparam int CHAR_A  = 10;
    localparam int CHAR_Z  = 35;
    localparam int NAME_W  = 18;
    localparam int SCORE_W = 16;

    typedef logic [5:0]         char_t;
    typedef logic [NAME_W-1:0]  name_t;
    typedef logic [SCORE_W-1:0] score_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CHECK  = 3'd1,
        ENTRY  = 3'd2,
        INSERT = 3'd3,
        DONE   = 3'd4
    } state_t;

    typedef struct packed {
        name_t  name;
        score_t score;
    } entry_t;

    localparam name_t  NAME_AAA  = {3{6'(CHAR_A)}};
    localparam entry_t ENTRY_RST = {NAME_AAA, 16'h0000};

    // Letters only: stepping wraps within A..Z and never lands on a digit code.
    function automatic char_t char_step(input char_t c, input logic up);
        if (up)
            return (c == char_t'(CHAR_Z)) ? char_t'(CHAR_A) : c + 6'd1;
        else
            return (c == char_t'(CHAR_A)) ? char_t'(CHAR_Z) : c - 6'd1;
    endfunction
endpackage

// File: rtl/highscore_table_ctrl_if.sv
// Control pulses in, table/preview words out, for the high-score controller.
// Pulse-based, no backpressure: anything arriving outside its accepting state is dropped.
interface highscore_table_ctrl_if;
    import hs_defs::*;

    logic        game_over;
    score_t      final_score;
    logic        table_clear;
    logic        btn_up;
    logic        btn_down;
    logic        btn_confirm;
    logic [31:0] name1, name2, name3;
    logic [31:0] score1, score2, score3;
    name_t       edit_name;
    logic [1:0]  cursor;
    logic        entering;
    logic [1:0]  rank;
    logic        done;

    modport master (
        output game_over, final_score, table_clear, btn_up, btn_down, btn_confirm,
        input  name1, name2, name3, score1, score2, score3,
        input  edit_name, cursor, entering, rank, done
    );

    modport slave (
        input  game_over, final_score, table_clear, btn_up, btn_down, btn_confirm,
        output name1, name2, name3, score1, score2, score3,
        output edit_name, cursor, entering, rank, done
    );
endinterface

// File: rtl/highscore_table_ctrl_rank_compare.sv
// Ranks a candidate BCD score against the three stored scores; ties do not displace.
// Purely combinational, no backpressure.
module hs_rank_compare
    import hs_defs::*;
(
    input  score_t     cand,
    input  score_t     s1,
    input  score_t     s2,
    input  score_t     s3,
    output logic [1:0] rank
);
    // Plain unsigned compare orders packed BCD correctly digit by digit.
    always_comb begin
        if (cand > s1)      rank = 2'd1;
        else if (cand > s2) rank = 2'd2;
        else if (cand > s3) rank = 2'd3;
        else                rank = 2'd0;
    end
endmodule

// File: rtl/highscore_table_ctrl.sv
// Top-3 high-score table with 3-letter initials entry; game_over to ENTRY in 2 cycles, done 1 cycle after INSERT.
// No backpressure: pulses are only honoured in their accepting state, otherwise dropped.
module highscore_table_ctrl
    import hs_defs::*;
(
    input  logic                   clock,
    input  logic                   reset,
    highscore_table_ctrl_if.slave  hs
);
    state_t     state, state_nxt;
    entry_t     ent1, ent2, ent3;
    entry_t     new_ent;
    score_t     cand;
    name_t      edit_name_q;
    logic [1:0] cursor_q;
    logic [1:0] rank_q;
    logic [1:0] rank_c;
    char_t      cur_char;
    char_t      new_char;
    logic       step_vld;

    hs_rank_compare u_rank (
        .cand (cand),
        .s1   (ent1.score),
        .s2   (ent2.score),
        .s3   (ent3.score),
        .rank (rank_c)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (hs.game_over) state_nxt = CHECK;
            CHECK:  state_nxt = (rank_c == 2'd0) ? DONE : ENTRY;
            ENTRY:  if (hs.btn_confirm && cursor_q == 2'd0) state_nxt = INSERT;
            INSERT: state_nxt = DONE;
            DONE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        hs.entering = (state == ENTRY);
        hs.done     = (state == DONE);
    end

    always_comb begin
        case (cursor_q)
            2'd2:    cur_char = edit_name_q[17:12];
            2'd1:    cur_char = edit_name_q[11:6];
            default: cur_char = edit_name_q[5:0];
        endcase
    end

    assign step_vld = hs.btn_up ^ hs.btn_down;
    assign new_char = char_step(cur_char, hs.btn_up);
    assign new_ent  = {edit_name_q, cand};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ent1        <= ENTRY_RST;
            ent2        <= ENTRY_RST;
            ent3        <= ENTRY_RST;
            cand        <= '0;
            edit_name_q <= NAME_AAA;
            cursor_q    <= 2'd2;
            rank_q      <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (hs.game_over) begin
                        cand <= hs.final_score;
                    end else if (hs.table_clear) begin
                        ent1 <= ENTRY_RST;
                        ent2 <= ENTRY_RST;
                        ent3 <= ENTRY_RST;
                    end
                end
                CHECK: begin
                    rank_q <= rank_c;
                    if (rank_c != 2'd0) begin
                        edit_name_q <= NAME_AAA;
                        cursor_q    <= 2'd2;
                    end
                end
                ENTRY: begin
                    // Confirm wins over up/down, so a combined press never edits the char.
                    if (hs.btn_confirm) begin
                        if (cursor_q != 2'd0) cursor_q <= cursor_q - 2'd1;
                    end else if (step_vld) begin
                        case (cursor_q)
                            2'd2:    edit_name_q[17:12] <= new_char;
                            2'd1:    edit_name_q[11:6]  <= new_char;
                            default: edit_name_q[5:0]   <= new_char;
                        endcase
                    end
                end
                INSERT: begin
                    case (rank_q)
                        2'd1: begin
                            ent3 <= ent2;
                            ent2 <= ent1;
                            ent1 <= new_ent;
                        end
                        2'd2: begin
                            ent3 <= ent2;
                            ent2 <= new_ent;
                        end
                        2'd3:    ent3 <= new_ent;
                        default: ;
                    endcase
                end
                DONE:    rank_q <= 2'd0;
                default: ;
            endcase
        end
    end

    assign hs.name1     = {14'b0, ent1.name};
    assign hs.name2     = {14'b0, ent2.name};
    assign hs.name3     = {14'b0, ent3.name};
    assign hs.score1    = {16'b0, ent1.score};
    assign hs.score2    = {16'b0, ent2.score};
    assign hs.score3    = {16'b0, ent3.score};
    assign hs.edit_name = edit_name_q;
    assign hs.cursor    = cursor_q;
    assign hs.rank      = rank_q;
endmodule
